multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/rv_mc_pkg.sv | 69 ++++++
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/aludec.sv | 36 +++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv_mc_pkg.sv
// Shared definitions for the multicycle RISC-V controller: FSM state encoding,
// opcode constants, datapath source-select encodings and ALU operation codes.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal,
    StIllegal
  } state_t;

  // Opcodes
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  // ALU source A select
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcAReg   = 2'b10;

  // ALU source B select
  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // Result select
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // Memory address select
  localparam logic AdrPc     = 1'b0;
  localparam logic AdrResult = 1'b1;

  // Main-decoder ALUOp
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALU control encoding
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  // Immediate format select derived purely from the opcode.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OpStore: return 2'b01;
      OpBeq:   return 2'b10;
      OpJal:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
//   master: datapath side, drives instruction fields, zero flag and mem_ready.
//   slave : controller side, drives enables, selects, halt and instret.
interface multicycle_ctrl_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic [6:0]          op;
  logic [2:0]          funct3;
  logic                funct7b5;
  logic                zero;
  logic                mem_ready;

  logic                pc_write;
  logic                adr_src;
  logic                mem_write;
  logic                ir_write;
  logic                reg_write;
  logic [1:0]          result_src;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          imm_src;
  logic [2:0]          alu_control;
  logic                halt;
  logic [RETIRE_W-1:0] instret;

  modport master (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
    input  result_src, alu_src_a, alu_src_b, imm_src, alu_control, halt, instret
  );

  modport slave (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
    output result_src, alu_src_a, alu_src_b, imm_src, alu_control, halt, instret
  );
endinterface

// File: rtl/aludec.sv
// ALU decoder: maps the main-decoder ALUOp plus instruction fields onto the
// ALU control code.
//   alu_op_i      : 00 add, 01 sub, 10 decode from funct3/funct7
//   funct3_i      : instruction funct3
//   funct7b5_i    : instruction bit 30
//   op_b5_i       : opcode bit 5 (distinguishes R-type from I-type)
//   alu_control_o : ALU operation
module aludec
  import rv_mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op_b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = AluAdd;
    case (alu_op_i)
      AluOpAdd: alu_control_o = AluAdd;
      AluOpSub: alu_control_o = AluSub;
      default: begin
        case (funct3_i)
          // Only R-type may subtract; addi with imm bit 10 set is still add.
          3'b000:  alu_control_o = (funct7b5_i & op_b5_i) ? AluSub : AluAdd;
          3'b010:  alu_control_o = AluSlt;
          3'b110:  alu_control_o = AluOr;
          3'b111:  alu_control_o = AluAnd;
          default: alu_control_o = AluAdd;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control unit: instruction-sequencing FSM, datapath
// enable/select generation and a retired-instruction counter.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : controller side of multicycle_ctrl_if (instruction fields, zero,
//           mem_ready in; enables, selects, alu_control, halt, instret out)
module multicycle_ctrl #(
  parameter int unsigned RETIRE_W = 32
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.slave  bus
);
  import rv_mc_pkg::*;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] instret_q;
  logic                retire;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpBeq:           state_d = StBeq;
          OpJal:           state_d = StJal;
          default:         state_d = StIllegal;
        endcase
      end
      StMemAdr:   state_d = (bus.op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (bus.mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (bus.mem_ready) state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      StIllegal:  state_d = StIllegal;
      default:    state_d = StFetch;
    endcase
  end

  assign retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBeq) ||
                  ((state_q == StMemWrite) && bus.mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + RETIRE_W'(1);
    end
  end

  // Output decode. Enables depend on mem_ready/zero in the same cycle, so they
  // are decoded from the state register rather than registered themselves.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = AdrPc;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBReg;
    alu_op     = AluOpAdd;
    case (state_q)
      StFetch: begin
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
      end
      StMemRead:  adr_src = AdrResult;
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = AdrResult;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SrcAReg;
        alu_op    = AluOpFunct;
      end
      StExecuteI: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunct;
      end
      StAluWb:    reg_write = 1'b1;
      StBeq: begin
        alu_src_a = SrcAReg;
        alu_op    = AluOpSub;
        pc_write  = bus.zero;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    // Reset forces the state to FETCH asynchronously; also mask the writes so
    // a pending mem_ready cannot fire pc/ir writes while reset is held.
    if (!reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  aludec u_aludec (
    .alu_op_i      (alu_op),
    .funct3_i      (bus.funct3),
    .funct7b5_i    (bus.funct7b5),
    .op_b5_i       (bus.op[5]),
    .alu_control_o (bus.alu_control)
  );

  assign bus.pc_write   = pc_write;
  assign bus.adr_src    = adr_src;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.imm_src    = imm_src_of(bus.op);
  assign bus.halt       = (state_q == StIllegal);
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl. The stimulus process pushes the
// expected per-cycle outputs into a queue; the monitor pops and compares on
// each falling edge. A second instance with RETIRE_W=4 checks counter wrap.
module tb_multicycle_ctrl;
  import rv_mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5, zero, mem_ready;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.RETIRE_W(32)) bus ();
  multicycle_ctrl_if #(.RETIRE_W(4))  bus4 ();

  assign bus.op         = op;
  assign bus.funct3     = f3;
  assign bus.funct7b5   = f7b5;
  assign bus.zero       = zero;
  assign bus.mem_ready  = mem_ready;
  assign bus4.op        = op;
  assign bus4.funct3    = f3;
  assign bus4.funct7b5  = f7b5;
  assign bus4.zero      = zero;
  assign bus4.mem_ready = mem_ready;

  multicycle_ctrl #(.RETIRE_W(32)) dut  (.clk(clk), .reset(rst_n), .bus(bus));
  multicycle_ctrl #(.RETIRE_W(4))  dut4 (.clk(clk), .reset(rst_n), .bus(bus4));

  typedef struct {
    logic [20:0] v;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cnt   = '0;

  // Expected outputs packed as {state, pcw, irw, memw, regw, adr, res, a, b, imm, alu, halt}.
  function automatic logic [20:0] model(input state_t st, input logic mr, input logic z,
                                        input logic [2:0] xalu);
    state_t     s;
    logic       pcw, irw, memw, regw, adr, halt;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    s = rst_n ? st : StFetch;
    pcw = 0; irw = 0; memw = 0; regw = 0; adr = 0; halt = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    case (s)
      StFetch:    begin sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      StDecode:   begin sa = 2'b01; sb = 2'b01; end
      StMemAdr:   begin sa = 2'b10; sb = 2'b01; end
      StMemRead:  adr = 1'b1;
      StMemWb:    begin res = 2'b01; regw = 1'b1; end
      StMemWrite: begin adr = 1'b1; memw = 1'b1; end
      StExecuteR: begin sa = 2'b10; alu = xalu; end
      StExecuteI: begin sa = 2'b10; sb = 2'b01; alu = xalu; end
      StAluWb:    regw = 1'b1;
      StBeq:      begin sa = 2'b10; alu = 3'b001; pcw = z; end
      StJal:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      StIllegal:  halt = 1'b1;
      default: ;
    endcase
    if (!rst_n) begin pcw = 0; irw = 0; memw = 0; regw = 0; end
    return {s, pcw, irw, memw, regw, adr, res, sa, sb, imm, alu, halt};
  endfunction

  // Monitor
  initial begin : mon
    exp_t        e;
    logic [20:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        act = {dut.state_q, bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write,
               bus.adr_src, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
               bus.alu_control, bus.halt};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s outputs got=%h exp=%h", e.tag, act, e.v);
        end
        total++;
        if (bus.instret !== e.cnt || bus4.instret !== e.cnt[3:0]) begin
          bad++;
          $display("FAIL %s instret got=%0d/%0d exp=%0d/%0d", e.tag, bus.instret,
                   bus4.instret, e.cnt, e.cnt[3:0]);
        end
      end
    end
  end

  task automatic step(input state_t st, input logic mr, input logic z, input logic [2:0] xalu,
                      input string tag);
    exp_t e;
    mem_ready = mr;
    zero      = z;
    e.v   = model(st, mr, z, xalu);
    e.cnt = cnt;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst_n && (st == StMemWb || st == StAluWb || st == StBeq || (st == StMemWrite && mr)))
      cnt = cnt + 1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic b5);
    op = o; f3 = f; f7b5 = b5;
  endtask

  task automatic alu_instr(input logic [6:0] o, input logic [2:0] f, input logic b5,
                           input logic [2:0] xalu, input string tag);
    set_instr(o, f, b5);
    step(StFetch, 1, 0, 0, tag);
    step(StDecode, 1, 0, 0, tag);
    step((o == 7'b0110011) ? StExecuteR : StExecuteI, 1, 0, xalu, tag);
    step(StAluWb, 1, 0, 0, tag);
  endtask

  initial begin
    rst_n = 0; op = '0; f3 = '0; f7b5 = 0; zero = 0; mem_ready = 0;
    @(posedge clk);
    #1;
    step(StFetch, 1, 0, 0, "rst_hold");
    step(StFetch, 1, 1, 0, "rst_hold");
    rst_n = 1;

    alu_instr(7'b0110011, 3'b000, 0, 3'b000, "add");

    // lw with three wait cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 0);
    step(StFetch, 1, 0, 0, "lw");
    step(StDecode, 1, 0, 0, "lw");
    step(StMemAdr, 1, 0, 0, "lw");
    for (int i = 0; i < 3; i++) step(StMemRead, 0, 0, 0, "lw_wait");
    step(StMemRead, 1, 0, 0, "lw");
    step(StMemWb, 1, 0, 0, "lw");

    // sw with a fetch stall and one write wait
    set_instr(7'b0100011, 3'b010, 0);
    step(StFetch, 0, 0, 0, "sw_fstall");
    step(StFetch, 1, 0, 0, "sw");
    step(StDecode, 1, 0, 0, "sw");
    step(StMemAdr, 1, 0, 0, "sw");
    step(StMemWrite, 0, 0, 0, "sw_wait");
    step(StMemWrite, 1, 0, 0, "sw");

    set_instr(7'b1100011, 3'b000, 0);
    step(StFetch, 1, 0, 0, "beq_t");
    step(StDecode, 1, 0, 0, "beq_t");
    step(StBeq, 1, 1, 0, "beq_t");
    step(StFetch, 1, 0, 0, "beq_n");
    step(StDecode, 1, 0, 0, "beq_n");
    step(StBeq, 1, 0, 0, "beq_n");

    set_instr(7'b1101111, 3'b000, 0);
    step(StFetch, 1, 0, 0, "jal");
    step(StDecode, 1, 0, 0, "jal");
    step(StJal, 1, 0, 0, "jal");
    step(StAluWb, 1, 0, 0, "jal");

    alu_instr(7'b0110011, 3'b000, 1, 3'b001, "sub");
    alu_instr(7'b0110011, 3'b110, 0, 3'b011, "or");
    alu_instr(7'b0110011, 3'b111, 0, 3'b010, "and");
    alu_instr(7'b0110011, 3'b010, 0, 3'b101, "slt");
    alu_instr(7'b0110011, 3'b001, 0, 3'b000, "f3_other");
    alu_instr(7'b0010011, 3'b000, 1, 3'b000, "addi_b5");
    alu_instr(7'b0010011, 3'b110, 0, 3'b011, "ori");

    // Reset between edges while a store is pending
    set_instr(7'b0100011, 3'b010, 0);
    step(StFetch, 1, 0, 0, "sw_rst");
    step(StDecode, 1, 0, 0, "sw_rst");
    step(StMemAdr, 1, 0, 0, "sw_rst");
    step(StMemWrite, 0, 0, 0, "sw_rst_pend");
    rst_n = 0;
    cnt   = '0;
    step(StFetch, 1, 0, 0, "rst_mw");
    step(StFetch, 1, 0, 0, "rst_mw");
    rst_n = 1;
    alu_instr(7'b0110011, 3'b000, 0, 3'b000, "add_post_rst");

    // Illegal opcode: sticky halt until reset
    set_instr(7'b0000000, 3'b000, 0);
    step(StFetch, 1, 0, 0, "ill");
    step(StDecode, 1, 0, 0, "ill");
    for (int i = 0; i < 20; i++) step(StIllegal, (i % 2) == 1, (i % 2) == 0, 0, "ill_hold");
    rst_n = 0;
    cnt   = '0;
    step(StFetch, 1, 0, 0, "rst_ill");
    rst_n = 1;
    step(StFetch, 0, 0, 0, "post_ill");

    // 17 retirements wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) alu_instr(7'b0010011, 3'b000, 0, 3'b000, "wrap");
    total++;
    if (bus4.instret !== 4'd1) begin
      bad++;
      $display("FAIL wrap4 instret got=%0d exp=1", bus4.instret);
    end
    step(StFetch, 0, 0, 0, "wrap_end");

    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain queue got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
